simple_system_host_arb: RTL
===========================

Name: simple_system_host_arb

Overview:
- Round-robin arbiter that shares one ibex-style req/gnt/rvalid device port between NrHosts hosts, e.g. core data port plus a DMA or debug host.
- Sits between the hosts and one host slot of the system bus, so the bus can stay at NrHosts=1.
- Returns responses to the host that issued each request, using an in-order ID FIFO of outstanding transactions.

Parameters:
- NrHosts, 2, number of requesting hosts (2..8).
- DataWidth, 32, data bus width.
- AddressWidth, 32, address bus width.
- MaxOutstanding, 2, maximum granted-but-unanswered transactions (power of two, 1..8).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous active-low.
- host_req_i  in  NrHosts  per-host request.
- host_gnt_o  out  NrHosts  per-host grant.
- host_addr_i  in  NrHosts*AddressWidth  packed addresses; host h is at slice h.
- host_we_i  in  NrHosts  write enables.
- host_be_i  in  NrHosts*4  byte enables.
- host_wdata_i  in  NrHosts*DataWidth  write data.
- host_rvalid_o  out  NrHosts  per-host response valid.
- host_rdata_o  out  DataWidth  read data, broadcast to all hosts (qualified by host_rvalid_o).
- host_err_o  out  NrHosts  per-host error, valid with rvalid.
- dev_req_o  out  1  device request.
- dev_gnt_i  in  1  device grant.
- dev_addr_o  out  AddressWidth  device address.
- dev_we_o  out  1  device write enable.
- dev_be_o  out  4  device byte enables.
- dev_wdata_o  out  DataWidth  device write data.
- dev_rvalid_i  in  1  device response valid.
- dev_rdata_i  in  DataWidth  device read data.
- dev_err_i  in  1  device error.
- unexp_rsp_o  out  1  sticky flag: rvalid arrived with no transaction outstanding.

Behaviour:
- Reset values:
  - All outputs 0.
  - Round-robin pointer = 0.
  - FIFO empty, count = 0.
  - Lock cleared.
- Accept condition: accept = (count < MaxOutstanding).
- When accept is 0:
  - dev_req_o = 0.
  - All host_gnt_o = 0.
- Arbitration (combinational, same cycle):
  - Winner = first requesting host at or after the pointer, wrapping modulo NrHosts.
  - dev_req_o = accept & (any host_req_i | lock).
  - dev_addr/we/be/wdata are muxed from the selected host.
- Lock:
  - Set when dev_req_o=1 and dev_gnt_i=0; stores the selected index.
  - While set, the locked host stays selected regardless of other requests; payload must stay stable per the ibex protocol.
  - Cleared on dev_gnt_i.
- Grant:
  - host_gnt_o[sel] = dev_req_o & dev_gnt_i.
  - Zero latency from dev_gnt_i.
- On grant:
  - Push sel into the ID FIFO.
  - Pointer = (sel+1) mod NrHosts.
- Response routing:
  - On dev_rvalid_i with FIFO non-empty: pop the head h.
  - host_rvalid_o[h] = 1 in the same cycle; host_err_o[h] = dev_err_i; host_rdata_o = dev_rdata_i.
  - Responses are strictly in order.
  - Minimum request-to-response latency is the device latency; the arbiter adds no cycles.
- Simultaneous push and pop in one cycle:
  - Allowed; count is unchanged.
  - A pop in the same cycle does not raise accept; accept uses the registered count only.
- Unexpected response: dev_rvalid_i with FIFO empty.
  - The response is dropped; no host_rvalid_o.
  - unexp_rsp_o is set and stays 1 until reset.
- FIFO pointers wrap modulo MaxOutstanding; count width is clog2(MaxOutstanding+1).
- Single requester: it wins every cycle; round-robin has no effect.
- Reset mid-operation: FIFO, lock and pointer clear asynchronously; outstanding responses after reset count as unexpected.

Test Plan:
1. Host0 only, dev_gnt_i=1, device rvalid 1 cycle later, rdata=0xDEADBEEF -> host_gnt_o=01 in the request cycle; host_rvalid_o=01 next cycle with host_rdata_o=0xDEADBEEF.
2. Both hosts request continuously, dev_gnt_i=1, responses 1 cycle later -> grants alternate 01,10,01,10; each rvalid goes to the host granted 1 cycle earlier.
3. Host1 requests, dev_gnt_i=0 for 3 cycles, host0 then requests -> dev_addr_o stays host1's address; host1 is granted first when dev_gnt_i rises; host0 is granted the next cycle.
4. MaxOutstanding=2, device holds rvalid low, both hosts request -> two grants (01,10), then dev_req_o=0 until the first rvalid; that rvalid goes to host0 with host_err_o=01 when dev_err_i=1.
5. dev_rvalid_i pulsed with nothing outstanding -> no host_rvalid_o; unexp_rsp_o=1 and held until rst_ni is asserted.
6. rst_ni asserted with 2 outstanding, then released -> all outputs 0, count=0, next grant goes to host0 first.

Source files
------------

// File: rtl/simple_system_host_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | simple_system_host_arb: round-robin arbiter sharing one req/gnt/rvalid       |
// | device port among NrHosts hosts, with in-order response routing.             |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module simple_system_host_arb #(
   parameter int unsigned NrHosts        = 2,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned AddressWidth   = 32,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NrHosts-1:0]                host_req_i,
   output logic [NrHosts-1:0]                host_gnt_o,
   input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
   input  logic [NrHosts-1:0]                host_we_i,
   input  logic [NrHosts*4-1:0]              host_be_i,
   input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
   output logic [NrHosts-1:0]                host_rvalid_o,
   output logic [DataWidth-1:0]              host_rdata_o,
   output logic [NrHosts-1:0]                host_err_o,
   output logic                              dev_req_o,
   input  logic                              dev_gnt_i,
   output logic [AddressWidth-1:0]           dev_addr_o,
   output logic                              dev_we_o,
   output logic [3:0]                        dev_be_o,
   output logic [DataWidth-1:0]              dev_wdata_o,
   input  logic                              dev_rvalid_i,
   input  logic [DataWidth-1:0]              dev_rdata_i,
   input  logic                              dev_err_i,
   output logic                              unexp_rsp_o
);

   localparam int unsigned IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   logic [AddressWidth-1:0] addr_arr  [NrHosts];
   logic [DataWidth-1:0]    wdata_arr [NrHosts];
   logic [3:0]              be_arr    [NrHosts];

   generate
      for (genvar h = 0; h < NrHosts; h++) begin : g_unpack
         assign addr_arr[h]  = host_addr_i[h*AddressWidth +: AddressWidth];
         assign wdata_arr[h] = host_wdata_i[h*DataWidth +: DataWidth];
         assign be_arr[h]    = host_be_i[h*4 +: 4];
      end
   endgenerate

   logic [IdxW-1:0] rr_q, rr_d;
   logic            lock_q, lock_d;
   logic [IdxW-1:0] lock_idx_q, lock_idx_d;
   logic [IdxW-1:0] fifo_q [MaxOutstanding];
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            unexp_q, unexp_d;

   logic [IdxW-1:0] winner;
   logic [IdxW:0]   cand;
   logic [IdxW-1:0] sel;
   logic [IdxW-1:0] head;
   logic            accept;
   logic            grant;
   logic            push;
   logic            pop;

   // Scan downward so the first requester at or after rr_q is the last write.
   always_comb begin
      winner = rr_q;
      cand   = '0;
      for (int i = NrHosts - 1; i >= 0; i--) begin
         cand = {1'b0, rr_q} + (IdxW+1)'(i);
         if (cand >= (IdxW+1)'(NrHosts)) begin
            cand = cand - (IdxW+1)'(NrHosts);
         end
         if (host_req_i[cand[IdxW-1:0]]) begin
            winner = cand[IdxW-1:0];
         end
      end
   end

   assign sel       = lock_q ? lock_idx_q : winner;
   assign accept    = (cnt_q < CntW'(MaxOutstanding));
   assign dev_req_o = accept & ((|host_req_i) | lock_q);
   assign grant     = dev_req_o & dev_gnt_i;
   assign push      = grant;
   assign pop       = dev_rvalid_i & (cnt_q != '0);
   assign head      = fifo_q[rptr_q];

   always_comb begin
      dev_addr_o  = '0;
      dev_we_o    = 1'b0;
      dev_be_o    = '0;
      dev_wdata_o = '0;
      if (dev_req_o) begin
         dev_addr_o  = addr_arr[sel];
         dev_we_o    = host_we_i[sel];
         dev_be_o    = be_arr[sel];
         dev_wdata_o = wdata_arr[sel];
      end
   end

   always_comb begin
      host_gnt_o    = '0;
      host_rvalid_o = '0;
      host_err_o    = '0;
      host_rdata_o  = '0;
      if (grant) begin
         host_gnt_o[sel] = 1'b1;
      end
      if (pop) begin
         host_rvalid_o[head] = 1'b1;
         host_err_o[head]    = dev_err_i;
         host_rdata_o        = dev_rdata_i;
      end
   end

   assign unexp_rsp_o = unexp_q;

   always_comb begin
      rr_d       = rr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      cnt_d      = cnt_q;
      unexp_d    = unexp_q | (dev_rvalid_i & (cnt_q == '0));

      if (grant) begin
         rr_d   = (sel == IdxW'(NrHosts - 1)) ? '0 : sel + IdxW'(1);
         lock_d = 1'b0;
         wptr_d = (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + PtrW'(1);
      end else if (dev_req_o) begin
         // Hold the stalled host so its payload stays on the bus until granted.
         lock_d     = 1'b1;
         lock_idx_d = sel;
      end

      if (pop) begin
         rptr_d = (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + PtrW'(1);
      end

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         unexp_q    <= 1'b0;
         for (int i = 0; i < MaxOutstanding; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         rr_q       <= rr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         unexp_q    <= unexp_d;
         if (push) begin
            fifo_q[wptr_q] <= sel;
         end
      end
   end

endmodule
`default_nettype wire
